mdu_iter: RTL and testbench



---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_div_seq.sv | 93 +++++++++
 rtl/mdu_iter.sv | 210 +++++++++++++++++++++
 tb/tb_mdu_iter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings MDU_MULT..MDU_MSUBU (codes 4-7 are only meaningful when
//     the unit is built with MDU_MADD_EN defined)
//   - controller state type
//   - clog2 helper for WIDTH-derived counter sizes
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;
    localparam logic [2:0] MDU_MSUB  = 3'd6;
    localparam logic [2:0] MDU_MSUBU = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >>> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mdu_div_seq.sv
// mdu_div_seq: unsigned restoring divider, one quotient bit per cycle.
//   clk, reset  : clock, synchronous active-high reset
//   go          : load dividend/divisor and perform the first iteration
//   dividend    : unsigned dividend
//   divisor     : unsigned divisor (0 gives an all-ones quotient, unused)
//   quot, rem   : result registers
//   valid       : one-cycle pulse, quot/rem hold the final result
// The first iteration happens on the go edge, so the result is visible
// WIDTH cycles after go is sampled.
module mdu_div_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             valid
);

    localparam int CW = clog2(WIDTH);

    logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d, valid_q, valid_d;

    logic [WIDTH-1:0] src_r, src_q, src_d;
    logic [WIDTH:0]   r_sh;
    logic             take;
    logic [WIDTH-1:0] step_r, step_q;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        src_r  = go ? '0       : r_q;
        src_q  = go ? dividend : q_q;
        src_d  = go ? divisor  : d_q;
        r_sh   = {src_r, src_q[WIDTH-1]};
        take   = (r_sh >= {1'b0, src_d});
        step_r = take ? WIDTH'(r_sh - {1'b0, src_d}) : r_sh[WIDTH-1:0];
        step_q = {src_q[WIDTH-2:0], take};
    end

    always_comb begin
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        valid_d = 1'b0;
        if (go) begin
            q_d   = step_q;
            r_d   = step_r;
            d_d   = divisor;
            cnt_d = CW'(WIDTH - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            q_d   = step_q;
            r_d   = step_r;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                run_d   = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            valid_q <= valid_d;
        end
    end

    assign quot  = q_q;
    assign rem   = r_q;
    assign valid = valid_q;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multiply/divide unit owning the HI/LO registers.
//   clk, reset   : clock, synchronous active-high reset (aborts any op)
//   start, op    : launch an operation (accepted only when busy=0)
//   a, b         : rs/rt operands; a is also the mthi/mtlo data
//   hi_we, lo_we : mthi/mtlo, honoured only when idle and start=0
//   hi, lo       : architectural HI/LO
//   busy         : operation in flight
//   done         : one-cycle pulse when HI/LO have just been committed
// Mult/multu hold busy MULT_LAT cycles; div/divu hold busy WIDTH+1 cycles.
// Build option MDU_MADD_EN enables madd/maddu/msub/msubu (ops 4-7, latency
// MULT_LAT+1); without it those codes are ignored.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
`ifdef MDU_MADD_EN
    logic             acc_q, acc_d, sub_q, sub_d;
    logic             op_acc;
`endif

    logic             op_ok, op_div;

    always_comb begin
        op_ok  = 1'b0;
        op_div = 1'b0;
`ifdef MDU_MADD_EN
        op_acc = 1'b0;
`endif
        case (op)
            MDU_MULT, MDU_MULTU: op_ok = 1'b1;
            MDU_DIV, MDU_DIVU: begin
                op_ok  = 1'b1;
                op_div = 1'b1;
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
                op_ok  = 1'b1;
                op_acc = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Multiplier: operands are held in a_q/b_q for the whole latency, the
    // sign-extended product is truncated to 2*WIDTH bits.
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
    assign ext_a = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    assign ext_b = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    assign prod  = ext_a * ext_b;

    always_comb begin
        mul_res = prod;
`ifdef MDU_MADD_EN
        if (acc_q)
            mul_res = sub_q ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
    end

    // Divider: magnitudes in, sign fix-up on the way out.
    logic [WIDTH-1:0] abs_a, abs_b, div_quot, div_rem, quot_s, rem_s;
    logic             div_go, div_valid, neg_q, neg_r;

    assign abs_a  = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b  = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    assign neg_q  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign neg_r  = sgn_q & a_q[WIDTH-1];
    assign quot_s = neg_q ? -div_quot : div_quot;
    assign rem_s  = neg_r ? -div_rem : div_rem;
    // The first DIV cycle is the setup cycle: magnitudes go straight into
    // the divider, which also performs its first iteration on that edge.
    assign div_go = (state_q == ST_DIV) && (cnt_q == CNT_W'(WIDTH));

    mdu_div_seq #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .go       (div_go),
        .dividend (abs_a),
        .divisor  (abs_b),
        .quot     (div_quot),
        .rem      (div_rem),
        .valid    (div_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MDU_MADD_EN
        acc_d   = acc_q;
        sub_d   = sub_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_ok) begin
                        a_d   = a;
                        b_d   = b;
                        sgn_d = ~op[0];
                        if (op_div) begin
                            state_d = ST_DIV;
                            cnt_d   = CNT_W'(WIDTH);
                        end else begin
                            state_d = ST_MUL;
                            cnt_d   = CNT_W'(MULT_LAT - 1);
`ifdef MDU_MADD_EN
                            acc_d = op_acc;
                            sub_d = op[1];
                            if (op_acc)
                                cnt_d = CNT_W'(MULT_LAT);
`endif
                        end
                    end
                end else begin
                    if (hi_we) hi_d = a;
                    if (lo_we) lo_d = a;
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = mul_res;
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DIV: begin
                if (cnt_q != '0)
                    cnt_d = cnt_q - 1'b1;
                if (div_valid) begin
                    if (b_q != '0) begin
                        lo_d = quot_s;
                        hi_d = rem_s;
                    end
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MDU_MADD_EN
            acc_q   <= acc_d;
            sub_q   <= sub_d;
`endif
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of mdu_iter (WIDTH=32)
// against an arithmetic reference model of HI/LO.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    always #5 clk = ~clk;

    mdu_iter #(
        .WIDTH    (32),
        .MULT_LAT (5),
        .CNT_W    (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: new HI/LO from plain arithmetic; returns busy length (0 = ignored).
    function automatic int model(input logic [2:0] o, input logic [31:0] x, y, h, l,
                                 output logic [31:0] eh, output logic [31:0] el);
        longint      sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        eh = h;
        el = l;
        case (o)
            3'd0: begin p = sx * sy; {eh, el} = p; return 5; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; {eh, el} = p; return 5; end
            3'd2: begin
                if (y != 0) begin el = 32'(sx / sy); eh = 32'(sx % sy); end
                return 33;
            end
            3'd3: begin
                if (y != 0) begin el = x / y; eh = x % y; end
                return 33;
            end
            default: begin
`ifdef MDU_MADD_EN
                if (o[0]) p = {32'b0, x} * {32'b0, y};
                else      p = sx * sy;
                {eh, el} = o[1] ? ({h, l} - p) : ({h, l} + p);
                return 6;
`else
                return 0;
`endif
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where busy has fallen,
    // so consecutive calls issue back-to-back starts.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, y,
                          input bit inject, input bit with_hwe);
        logic [31:0] ehi, elo;
        int          elat, n, early_done;
        bit          moved;
        elat  = model(o, x, y, mhi, mlo, ehi, elo);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        hi_we = with_hwe;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        n = 0;
        early_done = 0;
        moved = 1'b0;
        while (busy && n < 100) begin
            n++;
            if (done) early_done++;
            if (hi !== mhi || lo !== mlo) moved = 1'b1;
            if (inject && n == 3) begin
                start = 1'b1;
                op    = 3'd1;
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("busy_len op%0d", o), 64'(n), 64'(elat));
        check("done_early", 64'(early_done), 64'd0);
        check("hilo_stable", 64'(moved), 64'd0);
        check("done_pulse", 64'(done), 64'(elat != 0));
        check($sformatf("hi op%0d a=%h b=%h", o, x, y), 64'(hi), 64'(ehi));
        check($sformatf("lo op%0d a=%h b=%h", o, x, y), 64'(lo), 64'(elo));
        mhi = ehi;
        mlo = elo;
    endtask

    task automatic mt(input bit hw, input bit lw, input logic [31:0] v);
        hi_we = hw;
        lo_we = lw;
        a     = v;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hw) mhi = v;
        if (lw) mlo = v;
        check("mt_hi", 64'(hi), 64'(mhi));
        check("mt_lo", 64'(lo), 64'(mlo));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y;
        bit          seen;

        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        check("mult_hi_k", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo_k", 64'(lo), 64'hFFFF_FFFA);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_hi_k", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo_k", 64'(lo), 64'h0000_0001);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_lo_k", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi_k", 64'(hi), 64'hFFFF_FFFF);

        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        run_op(3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
        check("divz_hi_k", 64'(hi), 64'h11);
        check("divz_lo_k", 64'(lo), 64'h22);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("ovf_lo_k", 64'(lo), 64'h8000_0000);
        check("ovf_hi_k", 64'(hi), 64'h0);

        run_op(3'd1, 32'h1234, 32'd2, 1'b0, 1'b1);
        check("start_hwe_hi_k", 64'(hi), 64'h0);
        check("start_hwe_lo_k", 64'(lo), 64'h2468);

        mt(1'b1, 1'b0, 32'h1234);
        check("mthi_k", 64'(hi), 64'h1234);

        run_op(3'd4, 32'd5, 32'd6, 1'b0, 1'b1);

        // Reset during a divide.
        start = 1'b1;
        op    = 3'd2;
        a     = 32'h0000_1000;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", 64'(seen), 64'd0);
        mhi = '0;
        mlo = '0;

`ifdef MDU_MADD_EN
        mt(1'b1, 1'b1, 32'h0);
        mt(1'b0, 1'b1, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd1, 32'd1, 1'b0, 1'b0);
        check("maddu_hi_k", 64'(hi), 64'h1);
        check("maddu_lo_k", 64'(lo), 64'h0);
`endif

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) o = 3'($urandom_range(4, 7));
            else                           o = 3'($urandom_range(0, 3));
            x = pick();
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            if ($urandom_range(0, 3) == 0)
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op(o, x, y, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
